// File: rtl/dma_arb_fsm.sv
// Four-channel DMA request arbiter and transfer sequencer (SI, S0..S4) driving
// hold request, channel acknowledges, address enables and register-block strobes.
module dma_arb_fsm (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic       HLDA,
  input  logic [3:0] TC,
  input  logic [7:0] commandReg,
  input  logic [7:0] xferMode,
  input  logic [3:0] maskReg,
  input  logic [3:0] swReq,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       AEN,
  output logic       ADSTB,
  output logic [1:0] activeCh,
  output logic       ldCurrAddrTemp,
  output logic       ldCurrWordTemp,
  output logic       ldTempCurrAddr,
  output logic       ldTempCurrWord,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_SI = 3'd0,
    ST_S0 = 3'd1,
    ST_S1 = 3'd2,
    ST_S2 = 3'd3,
    ST_S3 = 3'd4,
    ST_S4 = 3'd5
  } st_t;

  st_t        st;
  logic [1:0] rot_ptr;
  logic [3:0] dack_act;
  logic [3:0] valid;
  logic       any_valid;
  logic [1:0] rot_base;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic [1:0] mode;
  logic       burst_done;
  logic       in_xfer;

  assign state     = st;
  assign valid     = ((DREQ ^ {4{commandReg[6]}}) & ~maskReg) | swReq;
  assign any_valid = |valid;
  assign rot_base  = commandReg[4] ? rot_ptr : 2'd0;
  assign mode      = xferMode[{activeCh, 1'b0} +: 2];
  assign in_xfer   = (st == ST_S1) || (st == ST_S2) || (st == ST_S3) || (st == ST_S4);

  // Acknowledge is tracked active-high internally so reset does not depend on commandReg.
  assign DACK = commandReg[7] ? dack_act : ~dack_act;

  // Code 11 behaves as single; demand mode keeps going only while its request stays up.
  assign burst_done = TC[activeCh] | commandReg[2] | (mode == 2'b01) | (mode == 2'b11) |
                      ((mode == 2'b00) & ~valid[activeCh]);

  // Search starts at the highest-priority channel and wraps modulo 4.
  always_comb begin
    winner = rot_base;
    found  = 1'b0;
    cand   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = rot_base + 2'(i);
      if (!found && valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st             <= ST_SI;
      HRQ            <= 1'b0;
      AEN            <= 1'b0;
      ADSTB          <= 1'b0;
      activeCh       <= 2'd0;
      dack_act       <= 4'd0;
      rot_ptr        <= 2'd0;
      ldCurrAddrTemp <= 1'b0;
      ldCurrWordTemp <= 1'b0;
      ldTempCurrAddr <= 1'b0;
      ldTempCurrWord <= 1'b0;
    end else begin
      ADSTB          <= 1'b0;
      ldCurrAddrTemp <= 1'b0;
      ldCurrWordTemp <= 1'b0;
      ldTempCurrAddr <= 1'b0;
      ldTempCurrWord <= 1'b0;
      if (in_xfer && !HLDA) begin
        // Bus taken back mid-transfer: abandon without write-back.
        st       <= ST_SI;
        HRQ      <= 1'b0;
        AEN      <= 1'b0;
        dack_act <= 4'd0;
        rot_ptr  <= activeCh + 2'd1;
      end else begin
        case (st)
          ST_SI: begin
            if (!commandReg[2] && any_valid) begin
              st  <= ST_S0;
              HRQ <= 1'b1;
            end
          end
          ST_S0: begin
            if (commandReg[2] || !any_valid) begin
              st  <= ST_SI;
              HRQ <= 1'b0;
            end else if (HLDA) begin
              st             <= ST_S1;
              activeCh       <= winner;
              AEN            <= 1'b1;
              ADSTB          <= 1'b1;
              ldCurrAddrTemp <= 1'b1;
              ldCurrWordTemp <= 1'b1;
            end
          end
          ST_S1: begin
            st       <= ST_S2;
            dack_act <= 4'b0001 << activeCh;
          end
          ST_S2: begin
            st <= ST_S3;
          end
          ST_S3: begin
            st             <= ST_S4;
            ldTempCurrAddr <= 1'b1;
            ldTempCurrWord <= 1'b1;
          end
          ST_S4: begin
            dack_act <= 4'd0;
            if (burst_done) begin
              st      <= ST_SI;
              HRQ     <= 1'b0;
              AEN     <= 1'b0;
              rot_ptr <= activeCh + 2'd1;
            end else begin
              st             <= ST_S1;
              ADSTB          <= 1'b1;
              ldCurrAddrTemp <= 1'b1;
              ldCurrWordTemp <= 1'b1;
            end
          end
          default: begin
            st       <= ST_SI;
            HRQ      <= 1'b0;
            AEN      <= 1'b0;
            dack_act <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
